// File: rtl/clkdiv_glitchfree.sv
// Programmable glitch-free integer clock divider.
// Divisor changes and run/stop requests only act at whole-period boundaries,
// so clko never shows a phase shorter than the period it belongs to.
module clkdiv_glitchfree #(
  parameter int WIDTH   = 8,
  parameter int DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             div_wr,
  output logic             div_ack,
  output logic             clko,
  output logic             tick,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Reset divisor and its phase lengths, clamped the same way as runtime values
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DIV_RST);
  localparam logic [WIDTH-1:0] RST_N   = (RST_DIV < WIDTH'(2)) ? WIDTH'(2) : RST_DIV;
  localparam logic [WIDTH-1:0] RST_H   = RST_N >> 1;
  localparam logic [WIDTH-1:0] RST_L   = RST_N - RST_H;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cntNext;
  logic [WIDTH-1:0] r_curDiv;
  logic [WIDTH-1:0] r_pendDiv;
  logic             r_pending;
  logic [WIDTH-1:0] r_hLen;
  logic [WIDTH-1:0] r_lLen;
  logic             r_clko;
  logic             r_tick;
  logic             r_ack;
  logic             w_clkoNext;
  logic             w_boundary;
  logic [WIDTH-1:0] w_nextRaw;
  logic [WIDTH-1:0] w_nextN;
  logic [WIDTH-1:0] w_nextH;
  logic [WIDTH-1:0] w_nextL;

  // Divisor that would govern a period starting at this edge, with 0/1 clamped to 2
  always_comb begin
    w_nextRaw = r_pending ? r_pendDiv : r_curDiv;
    w_nextN   = (w_nextRaw < WIDTH'(2)) ? WIDTH'(2) : w_nextRaw;
    w_nextH   = w_nextN >> 1;
    w_nextL   = w_nextN - w_nextH;
  end

  // Next-state logic: phase counting and period-boundary detection
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_clkoNext  = r_clko;
    w_boundary  = 1'b0;
    case (r_state)
      IDLE: begin
        w_clkoNext = 1'b0;
        w_cntNext  = '0;
        if (en) begin
          w_boundary = 1'b1;
        end
      end
      HIGH: begin
        if (r_cnt == r_hLen) begin
          w_stateNext = LOW;
          w_cntNext   = WIDTH'(1);
          w_clkoNext  = 1'b0;
        end else begin
          w_cntNext = r_cnt + WIDTH'(1);
        end
      end
      LOW: begin
        if (r_cnt == r_lLen) begin
          if (en) begin
            w_boundary = 1'b1;
          end else begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_clkoNext  = 1'b0;
          end
        end else begin
          w_cntNext = r_cnt + WIDTH'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
        w_clkoNext  = 1'b0;
      end
    endcase
    if (w_boundary) begin
      w_stateNext = HIGH;
      w_cntNext   = WIDTH'(1);
      w_clkoNext  = 1'b1;
    end
  end

  // FSM state, phase counter and the flop-driven output clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_clko  <= 1'b0;
      r_tick  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_clko  <= w_clkoNext;
      r_tick  <= w_boundary;
      r_ack   <= w_boundary & r_pending;
    end
  end

  // Active divisor and phase lengths, latched only when a new period starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_curDiv <= RST_DIV;
      r_hLen   <= RST_H;
      r_lLen   <= RST_L;
    end else if (w_boundary) begin
      r_hLen <= w_nextH;
      r_lLen <= w_nextL;
      if (r_pending) begin
        r_curDiv <= r_pendDiv;
      end
    end
  end

  // Pending divisor: a fresh write always wins over the boundary clearing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendDiv <= '0;
      r_pending <= 1'b0;
    end else if (div_wr) begin
      r_pendDiv <= div;
      r_pending <= 1'b1;
    end else if (w_boundary) begin
      r_pending <= 1'b0;
    end
  end

  assign clko    = r_clko;
  assign tick    = r_tick;
  assign div_ack = r_ack;
  assign running = (r_state != IDLE);

endmodule
